// File: rtl/part2_pkg.sv
// Shared constants and channel-state encoding for the part2 serial demux/deserializer.
// Optional build macro DEMUX_PARITY_EN: 5-bit frames (4 data bits, then an odd-parity bit).
package part2_pkg;

  localparam int DATA_W = 4;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

`ifdef DEMUX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_P1    = 3'd1,
    ST_P2    = 3'd2,
    ST_P3    = 3'd3,
    ST_P4    = 3'd4
  } chan_state_t;

  // State that holds the second-to-last bit; the next bit completes the frame.
`ifdef DEMUX_PARITY_EN
  localparam chan_state_t ST_LAST = ST_P4;
`else
  localparam chan_state_t ST_LAST = ST_P3;
`endif

endpackage

// File: rtl/part2_chan_shift.sv
// Per-channel shift register and bit counter; done flags the final bit of a frame combinationally.
// No backpressure; frame length follows DEMUX_PARITY_EN through part2_pkg.
module part2_chan_shift
  import part2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [FRAME_LEN-2:0] bits,
  output logic                 done
);

  chan_state_t state;

  assign done = shift_en && (state == ST_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      bits  <= '0;
    end else if (clr) begin
      state <= ST_EMPTY;
      bits  <= '0;
    end else if (shift_en) begin
      if (done) begin
        // The completing bit goes straight to the top's word register.
        state <= ST_EMPTY;
        bits  <= '0;
      end else begin
        state <= chan_state_t'(state + 3'd1);
        bits  <= {bits[FRAME_LEN-3:0], bit_in};
      end
    end
  end

endmodule

// File: rtl/part2_demux_deser.sv
// 1:4 registered demux plus per-channel serial deserializer; 1-cycle latency, no backpressure.
// Optional build macro DEMUX_PARITY_EN adds a trailing odd-parity bit per frame.
module part2_demux_deser
  import part2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              T,
  input  logic              S0,
  input  logic              S1,
  output logic              Y0,
  output logic              Y1,
  output logic              Y2,
  output logic              Y3,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic [SEL_W-1:0]  word_ch,
  output logic              parity_err
);

  logic [SEL_W-1:0]     sel;
  logic [NUM_CH-1:0]    done;
  logic [FRAME_LEN-2:0] chan_bits [NUM_CH];
  logic [FRAME_LEN-1:0] frame;
  logic                 frame_err;
  logic [NUM_CH-1:0]    y_q;

  assign sel   = {S1, S0};
  assign frame = {chan_bits[sel], T};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    part2_chan_shift u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (en && (sel == SEL_W'(g))),
      .bit_in   (T),
      .bits     (chan_bits[g]),
      .done     (done[g])
    );
  end

`ifdef DEMUX_PARITY_EN
  // Odd parity: an even count of ones across all five bits is an error.
  assign frame_err = ~(^frame);
`else
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      word_ch    <= '0;
      parity_err <= 1'b0;
    end else begin
      y_q        <= en ? (NUM_CH'(T) << sel) : '0;
      word_valid <= 1'b0;
      if (!clr && done[sel]) begin
        word_valid <= 1'b1;
        word       <= frame[FRAME_LEN-1 -: DATA_W];
        word_ch    <= sel;
        parity_err <= frame_err;
      end
    end
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];

endmodule

// File: doc/part2_demux_deser.md
PART2_DEMUX_DESER -- requirements
Module: part2_demux_deser

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port en, input, 1, sample qualifier; T is consumed only in cycles with en=1.
REQ-004 SHALL have port clr, input, 1, synchronous discard of all partial frames.
REQ-005 SHALL have port T, input, 1, serial data bit from the upstream 4:1 mux.
REQ-006 SHALL have ports S0 and S1, input, 1 each, channel select; sel = {S1,S0}.
REQ-007 SHALL have ports Y0..Y3, output, 1 each, registered demux outputs.
REQ-008 SHALL have port word, output, 4, last completed frame, MSB first.
REQ-009 SHALL have port word_valid, output, 1, one-cycle pulse when word/word_ch update.
REQ-010 SHALL have port word_ch, output, 2, channel of the completed frame.
REQ-011 SHALL have port parity_err, output, 1, odd-parity failure flag qualified by word_valid.

Function
REQ-012 SHALL drive Y[sel] <= T and all other Y to 0 on each en=1 edge, giving 1-cycle latency.
REQ-013 SHALL drive all Y to 0 on any edge with en=0.
REQ-014 SHALL keep one shift register and one bit counter per channel; states EMPTY(0), P1, P2, P3 (and P4 with parity).
REQ-015 SHALL, on en=1, shift T into the LSB of channel sel's register and advance its counter; other channels hold.
REQ-016 SHALL, when the final bit of a frame arrives, load word with the 4 data bits, set word_ch=sel, pulse word_valid for exactly 1 cycle on the next edge, and return that channel to EMPTY.
REQ-017 SHALL hold word, word_ch and parity_err between frames; word_valid=0 otherwise.
REQ-018 SHALL allow frames on different channels to interleave arbitrarily; each channel's partial frame survives selection of other channels.
REQ-019 SHALL, with clr=1, return every channel to EMPTY and suppress any word_valid that would complete that cycle; clr has priority over en.
REQ-020 SHALL allow back-to-back frames on one channel: a word_valid every 4 (or 5) en cycles, no dead cycle.

Reset
REQ-021 SHALL, while rst=1, force Y0..Y3=0, word=4'h0, word_ch=0, word_valid=0, parity_err=0 and all counters and shift registers to EMPTY/0, independent of clk.
REQ-022 SHALL discard all partial frames on reset mid-frame; the first frame after release starts at bit 0.

Configuration
REQ-023 SHALL compile odd-parity framing when macro DEMUX_PARITY_EN is defined: frames are 5 bits (4 data then parity), completion on the 5th bit, parity_err=1 when the 5 bits have even weight.
REQ-024 SHALL, without DEMUX_PARITY_EN, use 4-bit frames and tie parity_err to 0; the port list is unchanged.

Structure
REQ-025 SHALL take DATA_W=4, NUM_CH=4, frame length constants and the channel-state enum from shared package part2_pkg.
REQ-026 SHALL instantiate one sub-module, part2_chan_shift (shift register, counter and completion flag per channel), NUM_CH times; the top holds the demux, the output mux and the registers.

Verification
REQ-027 SHALL cover: rst released, en=1, sel=2, T=1 -> next edge Y2=1, Y0=Y1=Y3=0.
REQ-028 SHALL cover: sel=1 for 4 en cycles, T=1,0,1,1 -> word=4'b1011, word_ch=1, single-cycle word_valid.
REQ-029 SHALL cover: interleave ch0 bits 1,1 then ch3 bits 0,1,0,1 then ch0 bits 0,0 -> word=4'h5/ch3 first, then word=4'hC/ch0.
REQ-030 SHALL cover: 2 bits into ch2, clr=1 for 1 cycle, then 4 bits 0,1,1,0 -> word=4'h6, no earlier word_valid.
REQ-031 SHALL cover: rst pulse asynchronous mid-frame after 3 bits -> outputs 0 immediately; next 4 bits 1,1,1,1 -> word=4'hF.
REQ-032 SHALL cover, with DEMUX_PARITY_EN: data 1,0,1,0 with parity 1 -> parity_err=0; data 1,0,1,0 with parity 0 -> parity_err=1.
